// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared definitions for the DDR read-port arbiter: FSM encoding, DDR bus widths
// and the frame buffer base addresses used by every frame reader.
package ddr_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DATA = 2'd2
  } arb_state_e;

  localparam int DDR_ADDR_W = 27;
  localparam int DDR_DATA_W = 128;

  // Frame buffer bases shared by the UART dump, HDR merge and display readers
  localparam logic [DDR_ADDR_W-1:0] FRAME_BASE_LOW  = 27'h000_0000;
  localparam logic [DDR_ADDR_W-1:0] FRAME_BASE_MID  = 27'h009_6000;
  localparam logic [DDR_ADDR_W-1:0] FRAME_BASE_HIGH = 27'h012_C000;
  localparam logic [DDR_ADDR_W-1:0] FRAME_BASE_HDR  = 27'h01C_2000;

endpackage

// File: rtl/ddr_rd_arbiter_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr,
// wrapping modulo N_REQ.
module rr_priority_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan ptr, ptr+1, ... and keep the first hit only
  always_comb begin
    int  cand;
    logic hit;
    cand  = 0;
    hit   = 1'b0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand  = (int'(ptr) + k) % N_REQ;
      hit   = req[IDX_W'(cand)] && !valid;
      idx   = hit ? IDX_W'(cand) : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read port between N_REQ frame readers,
// one outstanding read at a time, with a data-return watchdog.
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = DDR_ADDR_W,
  parameter int DATA_W  = DDR_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_rd,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  output logic [N_REQ-1:0]           req_ack,
  output logic [DATA_W-1:0]          req_data,
  output logic [N_REQ-1:0]           req_data_valid,
  output logic                       mem_rd_req,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rd_data,
  input  logic                       mem_rd_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic                       stray_err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_e         state_r, state_next_s;
  logic [ID_W-1:0]    ptr_r, ptr_next_s;
  logic [ID_W-1:0]    grant_id_r, grant_next_s;
  logic [WD_W-1:0]    wd_r, wd_next_s;
  logic               mem_rd_req_r, mem_req_next_s;
  logic [ADDR_W-1:0]  mem_rd_addr_r, mem_addr_next_s;
  logic [N_REQ-1:0]   req_ack_r, ack_next_s;
  logic [N_REQ-1:0]   req_dv_r, dv_next_s;
  logic [DATA_W-1:0]  req_data_r;
  logic               data_load_s;
  logic               busy_r, busy_next_s;
  logic               timeout_err_r, timeout_next_s;
  logic               stray_err_r, stray_next_s;
  logic               pick_valid_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic [ADDR_W-1:0]  addr_sel_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    next_ptr = (id == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : id + ID_W'(1);
  endfunction

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req_rd),
    .ptr   (ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  // Address mux for the picked requester (AND-OR so no priority chain is implied)
  always_comb begin
    addr_sel_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      addr_sel_s = addr_sel_s |
                   ({ADDR_W{pick_idx_s == ID_W'(i)}} & req_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  // Next-state and next-output decode; pulses default low, latches default to hold
  always_comb begin
    state_next_s    = state_r;
    ptr_next_s      = ptr_r;
    grant_next_s    = grant_id_r;
    wd_next_s       = wd_r;
    mem_req_next_s  = mem_rd_req_r;
    mem_addr_next_s = mem_rd_addr_r;
    ack_next_s      = '0;
    dv_next_s       = '0;
    data_load_s     = 1'b0;
    timeout_next_s  = 1'b0;
    stray_next_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stray_next_s = mem_rd_valid;
        if (pick_valid_s) begin
          grant_next_s    = pick_idx_s;
          mem_addr_next_s = addr_sel_s;
          mem_req_next_s  = 1'b1;
          state_next_s    = ST_ISSUE;
        end else begin
          state_next_s    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          mem_req_next_s = 1'b0;
          ack_next_s     = onehot(grant_id_r);
          wd_next_s      = '0;
          // Data may already be on the bus in the accept cycle
          if (mem_rd_valid) begin
            data_load_s  = 1'b1;
            dv_next_s    = onehot(grant_id_r);
            ptr_next_s   = next_ptr(grant_id_r);
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_DATA;
          end
        end else begin
          stray_next_s = mem_rd_valid;
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT_DATA: begin
        if (mem_rd_valid) begin
          data_load_s    = 1'b1;
          dv_next_s      = onehot(grant_id_r);
          ptr_next_s     = next_ptr(grant_id_r);
          state_next_s   = ST_IDLE;
        end else if (wd_r == WD_LAST) begin
          timeout_next_s = 1'b1;
          ptr_next_s     = next_ptr(grant_id_r);
          state_next_s   = ST_IDLE;
        end else begin
          wd_next_s      = wd_r + WD_W'(1);
          state_next_s   = ST_WAIT_DATA;
        end
      end
      default: begin
        mem_req_next_s = 1'b0;
        state_next_s   = ST_IDLE;
      end
    endcase
    busy_next_s = (state_next_s != ST_IDLE);
  end

  // State, grant, watchdog and output registers; rst clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      grant_id_r    <= '0;
      wd_r          <= '0;
      mem_rd_req_r  <= 1'b0;
      mem_rd_addr_r <= '0;
      req_ack_r     <= '0;
      req_dv_r      <= '0;
      req_data_r    <= '0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      stray_err_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      ptr_r         <= ptr_next_s;
      grant_id_r    <= grant_next_s;
      wd_r          <= wd_next_s;
      mem_rd_req_r  <= mem_req_next_s;
      mem_rd_addr_r <= mem_addr_next_s;
      req_ack_r     <= ack_next_s;
      req_dv_r      <= dv_next_s;
      busy_r        <= busy_next_s;
      timeout_err_r <= timeout_next_s;
      stray_err_r   <= stray_next_s;
      if (data_load_s) begin
        req_data_r  <= mem_rd_data;
      end
    end
  end

  assign req_ack        = req_ack_r;
  assign req_data       = req_data_r;
  assign req_data_valid = req_dv_r;
  assign mem_rd_req     = mem_rd_req_r;
  assign mem_rd_addr    = mem_rd_addr_r;
  assign grant_id       = grant_id_r;
  assign busy           = busy_r;
  assign timeout_err    = timeout_err_r;
  assign stray_err      = stray_err_r;

endmodule
